// File: rtl/sha1_block_loader.sv
// SHA-1 block loader: pops BLOCK_WORDS words from the message FIFO into the core W-buffer,
// pulses core_start, then waits for core_done. Optional done watchdog: SHA1_LOADER_TIMEOUT_EN.
module sha1_block_loader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BLOCK_WORDS    = 16,
  parameter int unsigned IDX_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  input  logic                  core_ready,
  input  logic                  core_done,
  output logic                  core_wr,
  output logic [IDX_WIDTH-1:0]  core_widx,
  output logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_start,
  output logic                  busy,
  output logic [15:0]           blk_cnt,
  output logic                  timeout_err
);

  // One extra bit so the counter can hold BLOCK_WORDS itself.
  localparam int unsigned CntW = IDX_WIDTH + 1;

  if ((2 ** IDX_WIDTH) < BLOCK_WORDS || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("sha1_block_loader: IDX_WIDTH too small or TIMEOUT_CYCLES is zero");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       wcnt_q;
  logic                  core_wr_q;
  logic [IDX_WIDTH-1:0]  widx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [15:0]           blk_cnt_q;
  logic                  last_pop;
  logic                  timeout_evt;

  assign last_pop = fifo_pop && (wcnt_q == CntW'(BLOCK_WORDS - 1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; en and core_ready only matter in idle, so a started block always finishes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en && core_ready) state_d = StLoad;
      StLoad:  if (last_pop) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (core_done || timeout_evt) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    fifo_pop   = (state_q == StLoad) && !fifo_empty && (wcnt_q < CntW'(BLOCK_WORDS));
    core_start = (state_q == StStart);
    busy       = (state_q != StIdle);
  end

  // Datapath: FIFO data is only valid during the pop cycle, so it is captured on that edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt_q    <= '0;
      core_wr_q <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      blk_cnt_q <= '0;
    end else begin
      core_wr_q <= fifo_pop;
      if (fifo_pop) begin
        wdata_q <= fifo_dout;
        widx_q  <= wcnt_q[IDX_WIDTH-1:0];
        wcnt_q  <= wcnt_q + 1'b1;
      end else if (state_q == StStart) begin
        wcnt_q <= '0;
      end
      if (state_q == StWait && core_done) begin
        blk_cnt_q <= blk_cnt_q + 16'd1;
      end
    end
  end

  assign core_wr    = core_wr_q;
  assign core_widx  = widx_q;
  assign core_wdata = wdata_q;
  assign blk_cnt    = blk_cnt_q;

`ifdef SHA1_LOADER_TIMEOUT_EN
  localparam int unsigned WdRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WdW   = (WdRaw < 8) ? 8 : WdRaw;

  logic [WdW-1:0] wd_q;
  logic           tmo_err_q;

  // Fires on the edge ending the TIMEOUT_CYCLES-th wait cycle; a same-cycle done wins.
  assign timeout_evt = (state_q == StWait) && !core_done && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q      <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= timeout_evt;
      if (state_q != StWait) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_evt = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha1_block_loader.sv
// Scoreboard bench for sha1_block_loader: a queue-based FIFO model feeds the DUT, expected
// W-buffer writes and block counts are queued at stimulus time and checked by a monitor.
`timescale 1ns/1ps
module tb_sha1_block_loader;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 16;
  localparam int unsigned IW  = 4;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          rstn, en, fifo_empty, fifo_pop, core_ready, core_done;
  logic [DW-1:0] fifo_dout, core_wdata;
  logic          core_wr, core_start, busy, timeout_err;
  logic [IW-1:0] core_widx;
  logic [15:0]   blk_cnt;

  sha1_block_loader #(
    .DATA_WIDTH(DW), .BLOCK_WORDS(BW), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_pop(fifo_pop), .core_ready(core_ready), .core_done(core_done), .core_wr(core_wr),
    .core_widx(core_widx), .core_wdata(core_wdata), .core_start(core_start), .busy(busy),
    .blk_cnt(blk_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] fifo_q[$];
  wr_t           exp_wr_q[$];
  logic [15:0]   exp_blk_q[$];
  logic [15:0]   exp_blk = 16'd0;
  int            push_cnt = 0;
  int            checks = 0;
  int            errors = 0;
  int            wr_seen = 0;
  int            done_dly = 1;
  bit            no_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
  endtask

  // Word n pushed since reset lands at index n mod BW of its block.
  task automatic push_word(input logic [DW-1:0] w);
    wr_t e;
    fifo_q.push_back(w);
    e.idx  = IW'(push_cnt % BW);
    e.data = w;
    exp_wr_q.push_back(e);
    push_cnt++;
    refresh();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string name);
    int n = 0;
    @(negedge clk);
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, lvl);
    cyc(1);
  endtask

  task automatic wait_wr(input int target, input int bound, input string name);
    int n = 0;
    while (wr_seen < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, (wr_seen >= target), 1);
  endtask

  task automatic do_reset();
    #1 rstn = 1'b0;
    #1;
    check("rst_fifo_pop", fifo_pop, 0);
    check("rst_core_wr", core_wr, 0);
    check("rst_core_widx", core_widx, 0);
    check("rst_core_wdata", core_wdata, 0);
    check("rst_core_start", core_start, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    fifo_q.delete();
    exp_wr_q.delete();
    exp_blk_q.delete();
    push_cnt = 0;
    exp_blk  = 16'd0;
    refresh();
    cyc(2);
    #1 rstn = 1'b1;
  endtask

  // One full block with random data, random push gaps and random done latency.
  task automatic random_block();
    done_dly = $urandom_range(0, 4);
    en = 1'b1;
    cyc(1);
    en = 1'b0;
    for (int i = 0; i < BW; i++) begin
      push_word($urandom);
      cyc($urandom_range(0, 2));
    end
    wait_busy(1'b0, 200, "random_block_idle");
  endtask

  // FIFO model: the pop sampled mid-cycle is applied just after the edge.
  initial begin : fifo_proc
    bit p;
    forever begin
      @(negedge clk);
      p = fifo_pop;
      @(posedge clk);
      #1;
      if (p && rstn && fifo_q.size() > 0) fifo_q.delete(0);
      refresh();
    end
  end

  initial begin : monitor
    logic prev_busy;
    logic prev_start;
    wr_t  e;
    prev_busy  = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_busy  = 1'b0;
        prev_start = 1'b0;
        continue;
      end
      if (core_wr) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: idx %0d data %0h, none expected", core_widx, core_wdata);
        end else begin
          e = exp_wr_q.pop_front();
          check("write_idx", core_widx, e.idx);
          check("write_data", core_wdata, e.data);
        end
      end
      if (core_start) begin
        check("start_with_last_write", {core_wr, core_widx}, {1'b1, IW'(BW - 1)});
        check("start_single_cycle", prev_start, 0);
      end
      if (fifo_empty) check("no_pop_when_empty", fifo_pop, 0);
      if (prev_busy && !busy) begin
        if (exp_blk_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block_end: blk_cnt %0h, no block end expected", blk_cnt);
        end else begin
          check("blk_cnt", blk_cnt, exp_blk_q.pop_front());
        end
      end
      prev_busy  = busy;
      prev_start = core_start;
    end
  end

  // Core model: answers each start with a done pulse unless no_done is set.
  initial begin : responder
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && core_start) begin
        @(posedge clk);
        if (no_done) begin
`ifdef SHA1_LOADER_TIMEOUT_EN
          exp_blk_q.push_back(exp_blk);
          repeat (TMO) begin
            @(negedge clk);
            check("no_early_timeout", timeout_err, 0);
          end
          @(negedge clk);
          check("timeout_pulse", timeout_err, 1);
          check("timeout_to_idle", busy, 0);
          @(negedge clk);
          check("timeout_one_cycle", timeout_err, 0);
`endif
        end else begin
          repeat (done_dly) @(posedge clk);
          #1 core_done = 1'b1;
          exp_blk++;
          exp_blk_q.push_back(exp_blk);
          @(posedge clk);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int base;
    bit seen_tmo;
    rstn       = 1'b0;
    en         = 1'b0;
    core_ready = 1'b1;
    refresh();
    cyc(1);
    do_reset();

    // Not ready: en alone must not start a block.
    core_ready = 1'b0;
    en = 1'b1;
    push_word(32'h0000_0001);
    cyc(5);
    check("idle_when_not_ready", busy, 0);
    en = 1'b0;
    core_ready = 1'b1;
    cyc(1);
    for (int i = 2; i <= 16; i++) push_word(32'(i));

    // Test 1: pre-filled FIFO, done two cycles after start.
    done_dly = 1;
    en = 1'b1;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        en = 1'b0;
      end else if (n > 0) begin
        break;
      end
    end
    // Busy spans BW load cycles, one start cycle and done_dly+1 wait cycles.
    check("t1_busy_cycles", n, BW + 2 + done_dly);
    cyc(1);

    // Test 2: FIFO runs dry after 5 words for 3 cycles.
    base = wr_seen;
    for (int i = 0; i < 5; i++) push_word(32'hA000_0000 + 32'(i));
    en = 1'b1;
    wait_wr(base + 5, 100, "t2_first_five");
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_gap_no_write", core_wr, 0);
      check("t2_gap_idx_hold", core_widx, 4);
      check("t2_gap_busy", busy, 1);
    end
    cyc(1);
    for (int i = 5; i < 16; i++) push_word(32'hA000_0000 + 32'(i));
    wait_busy(1'b0, 100, "t2_idle");

    // Test 3: en dropped mid-load, block still completes and FSM stays idle.
    done_dly = $urandom_range(0, 4);
    base = wr_seen;
    for (int i = 0; i < 20; i++) push_word($urandom);
    en = 1'b1;
    wait_wr(base + 8, 100, "t3_eight_words");
    en = 1'b0;
    wait_busy(1'b0, 100, "t3_idle");
    cyc(10);
    check("t3_stay_idle", busy, 0);

    // Test 4: reset mid-load, then a clean block from index 0.
    base = wr_seen;
    for (int i = 0; i < 16; i++) push_word($urandom);
    en = 1'b1;
    wait_wr(base + 10, 100, "t4_ten_words");
    en = 1'b0;
    cyc(1);
    do_reset();
    random_block();

    // Test 5: counter wrap from 0xFFFF.
    force dut.blk_cnt_q = 16'hFFFF;
    cyc(1);
    release dut.blk_cnt_q;
    exp_blk = 16'hFFFF;
    random_block();
    random_block();
    for (int i = 0; i < 3; i++) random_block();

    // Test 6: core never answers.
    no_done = 1'b1;
    for (int i = 0; i < 16; i++) push_word($urandom);
    en = 1'b1;
    cyc(1);
    en = 1'b0;
`ifdef SHA1_LOADER_TIMEOUT_EN
    wait_busy(1'b0, 200, "t6_timeout_idle");
    cyc(5);
`else
    seen_tmo = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (timeout_err) seen_tmo = 1'b1;
    end
    check("t6_still_busy", busy, 1);
    check("t6_no_timeout", seen_tmo, 0);
    cyc(1);
    do_reset();
`endif
    no_done = 1'b0;
    random_block();

    check("pending_writes", exp_wr_q.size(), 0);
    check("pending_blocks", exp_blk_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
